// File: rtl/axi_wr_burst_slave_if.sv
// Bus bundle for the AXI write-slave front end: AW/W/B channels plus the
// valid/ready beat port toward the I2C command queue.
interface axi_wr_burst_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [LEN_WIDTH-1:0]    awlen;
    logic [SIZE_WIDTH-1:0]   awsize;
    logic [1:0]              awburst;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_addr;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [DATA_WIDTH/8-1:0] out_strb;
    logic                    out_last;
    logic                    out_err;

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        output out_valid, out_addr, out_data, out_strb, out_last,
        input  out_ready, out_err
    );

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        input  out_valid, out_addr, out_data, out_strb, out_last,
        output out_ready, out_err
    );
endinterface

// File: rtl/axi_wr_burst_slave.sv
// AXI write-slave front end: takes one AW burst at a time, forwards each W beat
// with its computed address downstream, and returns one B response per burst.
module axi_wr_burst_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi_wr_burst_slave_if.slave  bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [SIZE_WIDTH-1:0] MAX_SIZE = SIZE_WIDTH'($clog2(STRB_WIDTH));

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                 state, state_next;
    logic                   awready_q;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_next;
    logic [LEN_WIDTH-1:0]   len_q, count_q;
    logic [SIZE_WIDTH-1:0]  size_q;
    logic [1:0]             burst_q;
    logic                   drop_q, err_q;

    logic                   aw_hs, beat_hs, b_hs, last_beat;
    logic                   wready_int, out_valid_int;
    logic                   wrap_len_ok, drop_calc;
    logic [ADDR_WIDTH-1:0]  aw_size_bytes, size_bytes, span, wrap_lower, incr_addr;

    // Bursts we cannot map (reserved type, beat wider than the bus, malformed
    // WRAP) are swallowed silently and answered with SLVERR.
    assign aw_size_bytes = ADDR_WIDTH'(1) << bus.awsize;
    assign wrap_len_ok   = (bus.awlen == LEN_WIDTH'(1)) || (bus.awlen == LEN_WIDTH'(3)) ||
                           (bus.awlen == LEN_WIDTH'(7)) || (bus.awlen == LEN_WIDTH'(15));
    assign drop_calc     = (bus.awburst == BURST_RSVD) || (bus.awsize > MAX_SIZE) ||
                           ((bus.awburst == BURST_WRAP) &&
                            (!wrap_len_ok || ((bus.awaddr & (aw_size_bytes - ADDR_WIDTH'(1))) != '0)));

    assign last_beat     = (count_q == len_q);
    assign wready_int    = (state == DATA) && (drop_q || bus.out_ready);
    assign out_valid_int = (state == DATA) && !drop_q && bus.wvalid;

    assign aw_hs   = bus.awvalid && awready_q;
    assign beat_hs = bus.wvalid && wready_int;
    assign b_hs    = (state == RESP) && bus.bready;

    assign bus.awready   = awready_q;
    assign bus.wready    = wready_int;
    assign bus.bvalid    = (state == RESP);
    assign bus.bresp     = ((state == RESP) && (err_q || drop_q)) ? 2'b10 : 2'b00;
    assign bus.out_valid = out_valid_int;
    assign bus.out_addr  = out_valid_int ? addr_q    : '0;
    assign bus.out_data  = out_valid_int ? bus.wdata : '0;
    assign bus.out_strb  = out_valid_int ? bus.wstrb : '0;
    assign bus.out_last  = out_valid_int && last_beat;

    // Beat address generation; only the low span bits move for WRAP.
    assign size_bytes = ADDR_WIDTH'(1) << size_q;
    assign span       = size_bytes * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1));
    assign wrap_lower = addr_q & ~(span - ADDR_WIDTH'(1));
    assign incr_addr  = addr_q + size_bytes;

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            BURST_INCR: addr_next = (addr_q & ~(size_bytes - ADDR_WIDTH'(1))) + size_bytes;
            BURST_WRAP: addr_next = (incr_addr == wrap_lower + span) ? wrap_lower : incr_addr;
            default:    addr_next = addr_q;
        endcase
    end

    // NOTE: default assigned before the case so every path drives state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (aw_hs) state_next = DATA;
            DATA:    if (beat_hs && last_beat) state_next = RESP;
            RESP:    if (b_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            awready_q <= 1'b0;
        end else begin
            state     <= state_next;
            awready_q <= (state_next == IDLE);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            count_q <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (aw_hs) begin
            addr_q  <= bus.awaddr;
            len_q   <= bus.awlen;
            size_q  <= bus.awsize;
            burst_q <= bus.awburst;
            count_q <= '0;
            drop_q  <= drop_calc;
            err_q   <= 1'b0;
        end else if (beat_hs) begin
            count_q <= count_q + LEN_WIDTH'(1);
            addr_q  <= addr_next;
            // The burst always ends on our own count; a WLAST disagreement only flags the error.
            if ((!drop_q && bus.out_err) || (bus.wlast != last_beat))
                err_q <= 1'b1;
        end else if (b_hs) begin
            drop_q <= 1'b0;
            err_q  <= 1'b0;
        end
    end
endmodule
